// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the ALU result port, the memory load port and the
// register-file write port of the writeback arbiter.
//   slave  - seen by the arbiter
//   master - seen by the producers / register file side (or a testbench)
interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CountWidth = $clog2(FIFO_DEPTH) + 1;

  // ALU result source
  logic                  alu_valid;
  logic [4:0]            alu_rd;
  logic [63:0]           alu_data;
  logic                  alu_ready;

  // Memory (load) result source
  logic                  mem_valid;
  logic [4:0]            mem_rd;
  logic [63:0]           mem_data;
  logic [2:0]            mem_addr_lo;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic                  mem_ready;

  // Register-file write port
  logic                  regWrite;
  logic [4:0]            writeReg;
  logic [63:0]           writeData_R;

  // Status
  logic [CountWidth-1:0] fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data, mem_addr_lo, mem_size, mem_unsigned,
    output alu_ready, mem_ready,
    output regWrite, writeReg, writeData_R, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data, mem_addr_lo, mem_size, mem_unsigned,
    input  alu_ready, mem_ready,
    input  regWrite, writeReg, writeData_R, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage feeding the 32x64 register file write port.
// Merges single-cycle ALU results with load results (buffered in a small FIFO,
// then byte-aligned and sign/zero-extended) into one registered write per
// cycle. A starvation counter forces an ALU grant after STARVE_LIMIT cycles of
// waiting. Optional macro WB_RETIRE_CNT_EN adds a 64-bit retire_cnt output
// counting issued (non-x0) writes.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt
`endif
);

  localparam int PtrWidth    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CountWidth  = $clog2(FIFO_DEPTH) + 1;
  localparam int StarveWidth = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [2:0]  addrLo;
    logic [1:0]  size;
    logic        isUnsigned;
  } memEntry_t;

  memEntry_t              fifoMem [FIFO_DEPTH];
  logic [PtrWidth-1:0]    wrPtr;
  logic [PtrWidth-1:0]    rdPtr;
  logic [CountWidth-1:0]  fifoCount;
  logic [StarveWidth-1:0] starveCnt;

  logic                   memReady;
  logic                   pushEn;
  logic                   forceAlu;
  logic                   grantMem;
  logic                   grantAlu;

  memEntry_t              headEntry;
  logic [63:0]            shiftedData;
  logic [63:0]            loadData;
  logic [4:0]             winRd;
  logic [63:0]            winData;

  logic                   regWriteQ;
  logic [4:0]             writeRegQ;
  logic [63:0]            writeDataQ;

  // Handshakes and arbitration derive only from registered state and alu_valid;
  // everything is held off while reset is asserted.
  assign memReady = reset && (fifoCount != CountWidth'(FIFO_DEPTH));
  assign pushEn   = bus.mem_valid && memReady;
  assign forceAlu = bus.alu_valid && (starveCnt == StarveWidth'(STARVE_LIMIT));
  assign grantMem = reset && (fifoCount != '0) && !forceAlu;
  assign grantAlu = reset && bus.alu_valid && !grantMem;

  assign headEntry   = fifoMem[rdPtr];
  assign shiftedData = headEntry.data >> {headEntry.addrLo, 3'b000};

  // Keep the low 1/2/4/8 bytes of the aligned load and extend to 64 bits.
  always_comb begin
    loadData = shiftedData;
    case (headEntry.size)
      2'd0: loadData = {{56{shiftedData[7]  & ~headEntry.isUnsigned}}, shiftedData[7:0]};
      2'd1: loadData = {{48{shiftedData[15] & ~headEntry.isUnsigned}}, shiftedData[15:0]};
      2'd2: loadData = {{32{shiftedData[31] & ~headEntry.isUnsigned}}, shiftedData[31:0]};
      default: loadData = shiftedData;
    endcase
  end

  // Select the granted result for the output register.
  always_comb begin
    winRd   = bus.alu_rd;
    winData = bus.alu_data;
    if (grantMem) begin
      winRd   = headEntry.rd;
      winData = loadData;
    end
  end

  // FIFO storage: payload only, validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= '{rd: bus.mem_rd, data: bus.mem_data, addrLo: bus.mem_addr_lo,
                          size: bus.mem_size, isUnsigned: bus.mem_unsigned};
    end
  end

  // FIFO pointers and occupancy; a pop is exactly a memory grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushEn)   wrPtr <= wrPtr + PtrWidth'(1);
      if (grantMem) rdPtr <= rdPtr + PtrWidth'(1);
      case ({pushEn, grantMem})
        2'b10:   fifoCount <= fifoCount + CountWidth'(1);
        2'b01:   fifoCount <= fifoCount - CountWidth'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Count consecutive cycles the ALU waits; saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (bus.alu_valid && !grantAlu) begin
      if (starveCnt != StarveWidth'(STARVE_LIMIT)) starveCnt <= starveCnt + StarveWidth'(1);
    end else begin
      starveCnt <= '0;
    end
  end

  // Register-file write register; x0 writes are consumed but not enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (grantMem || grantAlu) begin
      regWriteQ  <= (winRd != 5'd0);
      writeRegQ  <= winRd;
      writeDataQ <= winData;
    end else begin
      regWriteQ  <= 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count every write that actually asserts regWrite (wraps naturally).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if ((grantMem || grantAlu) && (winRd != 5'd0)) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

  assign bus.alu_ready   = grantAlu;
  assign bus.mem_ready   = memReady;
  assign bus.regWrite    = regWriteQ;
  assign bus.writeReg    = writeRegQ;
  assign bus.writeData_R = writeDataQ;
  assign bus.fifo_count  = fifoCount;

endmodule
